// File: rtl/ex_stage_pipe_reg_if.sv
// DOF -> EX pipeline register bundle: DOF fields and hazard controls in,
// EX fields, PC/IR enables and stall/flush statistics out.
interface ex_stage_pipe_reg_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
);
  logic             dhs;
  logic             flush;
  logic             cnt_clr;
  logic [2:0]       da_dof;
  logic             rw_dof;
  logic             md_dof;
  logic             mw_dof;
  logic [4:0]       fs_dof;
  logic [DW-1:0]    a_dof;
  logic [DW-1:0]    b_dof;

  logic             pc_en;
  logic             ir_en;
  logic             valid_ex;
  logic [2:0]       da_ex;
  logic             rw_ex;
  logic             md_ex;
  logic             mw_ex;
  logic [4:0]       fs_ex;
  logic [DW-1:0]    a_ex;
  logic [DW-1:0]    b_ex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             stall_err;

  modport master (
    output dhs, flush, cnt_clr,
    output da_dof, rw_dof, md_dof, mw_dof,
    output fs_dof, a_dof, b_dof,
    input  pc_en, ir_en, valid_ex,
    input  da_ex, rw_ex, md_ex, mw_ex,
    input  fs_ex, a_ex, b_ex,
    input  stall_cnt, flush_cnt, stall_err
  );

  modport slave (
    input  dhs, flush, cnt_clr,
    input  da_dof, rw_dof, md_dof, mw_dof,
    input  fs_dof, a_dof, b_dof,
    output pc_en, ir_en, valid_ex,
    output da_ex, rw_ex, md_ex, mw_ex,
    output fs_ex, a_ex, b_ex,
    output stall_cnt, flush_cnt, stall_err
  );
endinterface

// File: rtl/ex_stage_pipe_reg.sv
// DOF/EX pipeline register: bubbles on stall or flush, holds PC/IR on
// stall, and keeps saturating stall/flush statistics.
module ex_stage_pipe_reg #(
  parameter int DW        = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_stage_pipe_reg_if.slave bus
);

  localparam int SW = $clog2(MAX_STALL + 2);
  localparam logic [SW-1:0] RUN_SAT = SW'(MAX_STALL + 1);
  localparam logic [SW-1:0] RUN_LIM = SW'(MAX_STALL);

  typedef struct packed {
    logic          valid;
    logic [2:0]    da;
    logic          rw;
    logic          md;
    logic          mw;
    logic [4:0]    fs;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } ex_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_STALL,
    ACT_FLUSH
  } act_e;

  act_e             act;
  ex_t              dof;
  ex_t              ex_d;
  ex_t              ex_q;
  logic [SW-1:0]    run_d;
  logic [SW-1:0]    run_q;
  logic [CNT_W-1:0] scnt_d;
  logic [CNT_W-1:0] scnt_q;
  logic [CNT_W-1:0] fcnt_d;
  logic [CNT_W-1:0] fcnt_q;
  logic             err_d;
  logic             err_q;

  assign dof = '{
    valid: 1'b1,
    da:    bus.da_dof,
    rw:    bus.rw_dof,
    md:    bus.md_dof,
    mw:    bus.mw_dof,
    fs:    bus.fs_dof,
    a:     bus.a_dof,
    b:     bus.b_dof
  };

  // Flush outranks stall; items kept disjoint
  always_comb begin
    act = ACT_LOAD;
    unique case (1'b1)
      bus.flush:               act = ACT_FLUSH;
      !bus.flush && !bus.dhs:  act = ACT_STALL;
      default:                 act = ACT_LOAD;
    endcase
  end

  always_comb begin
    ex_d   = '0;
    run_d  = '0;
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    err_d  = err_q;
    unique case (act)
      ACT_LOAD: ex_d = dof;
      ACT_STALL: begin
        run_d = (run_q == RUN_SAT) ? run_q
                                   : run_q + 1'b1;
        if (scnt_q != '1)
          scnt_d = scnt_q + 1'b1;
        if (run_q >= RUN_LIM)
          err_d = 1'b1;
      end
      ACT_FLUSH: begin
        if (fcnt_q != '1)
          fcnt_d = fcnt_q + 1'b1;
      end
      default: ex_d = '0;
    endcase
    // Clear beats any same-cycle increment
    if (bus.cnt_clr) begin
      scnt_d = '0;
      fcnt_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      run_q  <= '0;
      scnt_q <= '0;
      fcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      run_q  <= run_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.pc_en     = rst_n & (bus.dhs | bus.flush);
  assign bus.ir_en     = rst_n & (bus.dhs | bus.flush);
  assign bus.valid_ex  = ex_q.valid;
  assign bus.da_ex     = ex_q.da;
  assign bus.rw_ex     = ex_q.rw;
  assign bus.md_ex     = ex_q.md;
  assign bus.mw_ex     = ex_q.mw;
  assign bus.fs_ex     = ex_q.fs;
  assign bus.a_ex      = ex_q.a;
  assign bus.b_ex      = ex_q.b;
  assign bus.stall_cnt = scnt_q;
  assign bus.flush_cnt = fcnt_q;
  assign bus.stall_err = err_q;

endmodule

// File: tb/tb_ex_stage_pipe_reg.sv
// Random + directed bench for ex_stage_pipe_reg against a
// cycle-level behavioural model.
module tb_ex_stage_pipe_reg;

  localparam int DW        = 8;
  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 2;
  localparam int MAXC      = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors   = 0;
  int miscompar = 0;

  ex_stage_pipe_reg_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  ex_stage_pipe_reg #(
    .DW        (DW),
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // model state
  logic          m_valid = 1'b0;
  logic [2:0]    m_da    = '0;
  logic          m_rw    = 1'b0;
  logic          m_md    = 1'b0;
  logic          m_mw    = 1'b0;
  logic [4:0]    m_fs    = '0;
  logic [DW-1:0] m_a     = '0;
  logic [DW-1:0] m_b     = '0;
  int            m_scnt  = 0;
  int            m_fcnt  = 0;
  int            m_run   = 0;
  logic          m_err   = 1'b0;

  logic stall_only;
  logic bubble;
  assign stall_only = !bus.flush && !bus.dhs;
  assign bubble     = bus.flush || !bus.dhs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_da <= '0; m_rw <= 1'b0;
      m_md <= 1'b0; m_mw <= 1'b0; m_fs <= '0;
      m_a <= '0; m_b <= '0;
      m_scnt <= 0; m_fcnt <= 0; m_run <= 0;
      m_err <= 1'b0;
    end else begin
      m_valid <= !bubble;
      m_da    <= bubble ? 3'd0 : bus.da_dof;
      m_rw    <= bubble ? 1'b0 : bus.rw_dof;
      m_md    <= bubble ? 1'b0 : bus.md_dof;
      m_mw    <= bubble ? 1'b0 : bus.mw_dof;
      m_fs    <= bubble ? 5'd0 : bus.fs_dof;
      m_a     <= bubble ? '0 : bus.a_dof;
      m_b     <= bubble ? '0 : bus.b_dof;
      m_run   <= stall_only ? m_run + 1 : 0;
      if (bus.cnt_clr) begin
        m_scnt <= 0;
        m_fcnt <= 0;
        m_err  <= 1'b0;
      end else begin
        if (stall_only && m_scnt < MAXC) m_scnt <= m_scnt + 1;
        if (bus.flush && m_fcnt < MAXC)  m_fcnt <= m_fcnt + 1;
        if (stall_only && (m_run + 1) > MAX_STALL) m_err <= 1'b1;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompar++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic en_exp;
    en_exp = rst_n & (bus.dhs | bus.flush);
    chk("pc_en",     32'(bus.pc_en),     32'(en_exp));
    chk("ir_en",     32'(bus.ir_en),     32'(en_exp));
    chk("valid_ex",  32'(bus.valid_ex),  32'(m_valid));
    chk("da_ex",     32'(bus.da_ex),     32'(m_da));
    chk("rw_ex",     32'(bus.rw_ex),     32'(m_rw));
    chk("md_ex",     32'(bus.md_ex),     32'(m_md));
    chk("mw_ex",     32'(bus.mw_ex),     32'(m_mw));
    chk("fs_ex",     32'(bus.fs_ex),     32'(m_fs));
    chk("a_ex",      32'(bus.a_ex),      32'(m_a));
    chk("b_ex",      32'(bus.b_ex),      32'(m_b));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fcnt));
    chk("stall_err", 32'(bus.stall_err), 32'(m_err));
  end

  task automatic drive(input logic dhs, input logic flush,
                       input logic clr, input logic [2:0] da,
                       input logic rw, input logic [4:0] fs,
                       input logic [7:0] a, input logic [7:0] b);
    bus.dhs     = dhs;
    bus.flush   = flush;
    bus.cnt_clr = clr;
    bus.da_dof  = da;
    bus.rw_dof  = rw;
    bus.md_dof  = 1'b0;
    bus.mw_dof  = 1'b0;
    bus.fs_dof  = fs;
    bus.a_dof   = a;
    bus.b_dof   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 8'h00, 8'h00);
    tick();
    tick();
    chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
    chk("rst_valid", 32'(bus.valid_ex), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_pc_en", 32'(bus.pc_en), 32'd1);

    drive(1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 5'h02, 8'h12, 8'h34);
    tick();
    chk("norm_valid", 32'(bus.valid_ex), 32'd1);
    chk("norm_da",    32'(bus.da_ex),    32'd3);
    chk("norm_rw",    32'(bus.rw_ex),    32'd1);
    chk("norm_fs",    32'(bus.fs_ex),    32'h02);
    chk("norm_a",     32'(bus.a_ex),     32'h12);
    chk("norm_b",     32'(bus.b_ex),     32'h34);

    drive(1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 5'h03, 8'h56, 8'h78);
    #1;
    chk("stall_pc_en", 32'(bus.pc_en), 32'd0);
    chk("stall_ir_en", 32'(bus.ir_en), 32'd0);
    tick();
    chk("stall_valid", 32'(bus.valid_ex),  32'd0);
    chk("stall_da",    32'(bus.da_ex),     32'd0);
    chk("stall_rw",    32'(bus.rw_ex),     32'd0);
    chk("stall_cnt1",  32'(bus.stall_cnt), 32'd1);
    chk("stall_err0",  32'(bus.stall_err), 32'd0);

    drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 5'd1, 8'h01, 8'h02);
    tick();
    tick();
    chk("ovr_err_2", 32'(bus.stall_err), 32'd0);
    tick();
    chk("ovr_err_3", 32'(bus.stall_err), 32'd1);
    chk("ovr_cnt_3", 32'(bus.stall_cnt), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 5'd1, 8'h01, 8'h02);
    tick();
    chk("ovr_sticky", 32'(bus.stall_err), 32'd1);

    drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'd6, 1'b1, 5'h1f, 8'hff, 8'hee);
    #1;
    chk("fl_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    chk("fl_valid", 32'(bus.valid_ex),  32'd0);
    chk("fl_fcnt",  32'(bus.flush_cnt), 32'd1);
    chk("fl_scnt",  32'(bus.stall_cnt), 32'd0);
    chk("fl_err",   32'(bus.stall_err), 32'd0);

    drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 5'd2, 8'h22, 8'h33);
    repeat (21) tick();
    chk("sat_cnt", 32'(bus.stall_cnt), 32'hF);
    chk("sat_err", 32'(bus.stall_err), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 5'd2, 8'h22, 8'h33);
    tick();
    chk("clr_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("clr_err", 32'(bus.stall_err), 32'd0);

    drive(1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 5'h04, 8'h9a, 8'hbc);
    tick();
    chk("pre_valid", 32'(bus.valid_ex), 32'd1);
    chk("pre_da",    32'(bus.da_ex),    32'd5);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.valid_ex),  32'd0);
    chk("ar_da",    32'(bus.da_ex),     32'd0);
    chk("ar_a",     32'(bus.a_ex),      32'd0);
    chk("ar_fcnt",  32'(bus.flush_cnt), 32'd0);
    chk("ar_pc_en", 32'(bus.pc_en),     32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 8'h00, 8'h00);
    #1;
    chk("ar_rel_pc_en", 32'(bus.pc_en), 32'd1);
    tick();

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0,
            3'($urandom), 1'($urandom),
            5'($urandom), 8'($urandom), 8'($urandom));
      bus.md_dof = 1'($urandom);
      bus.mw_dof = 1'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompar);
    $finish;
  end

endmodule
